// File: rtl/tdp_ram_arbiter.sv
// tdp_ram_arbiter: round-robin arbiter that shares a true dual-port RAM among NUM_REQ requesters,
// granting up to two hazard-free accesses per cycle and routing read data back one cycle later.
module tdp_ram_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_REQ    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
   output logic                           ena,
   output logic                           wea,
   output logic [ADDR_WIDTH-1:0]          addra,
   output logic [DATA_WIDTH-1:0]          dina,
   output logic                           enb,
   output logic                           web,
   output logic [ADDR_WIDTH-1:0]          addrb,
   output logic [DATA_WIDTH-1:0]          dinb,
   input  logic [DATA_WIDTH-1:0]          douta,
   input  logic [DATA_WIDTH-1:0]          doutb
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [ADDR_WIDTH-1:0] addr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata [NUM_REQ];
   logic [IDX_W-1:0]      rr_q, rr_d, a_idx, b_idx, last_idx;
   logic                  a_fnd, b_fnd, gnt_a, gnt_b;
   logic                  tag_a_vld_q, tag_a_vld_d, tag_b_vld_q, tag_b_vld_d;
   logic [IDX_W-1:0]      tag_a_idx_q, tag_b_idx_q;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan from rr_q; B takes the first later requester that does not hazard against A.
   always_comb begin : arb
      int j;
      a_fnd = 1'b0;
      b_fnd = 1'b0;
      a_idx = '0;
      b_idx = '0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_q) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req_valid[j]) begin
            if (!a_fnd) begin
               a_fnd = 1'b1;
               a_idx = IDX_W'(j);
            end else if (!b_fnd && !((addr[j] == addr[a_idx]) && (req_we[j] || req_we[a_idx]))) begin
               b_fnd = 1'b1;
               b_idx = IDX_W'(j);
            end
         end
      end
   end

   assign gnt_a = a_fnd & rst_n;
   assign gnt_b = b_fnd & rst_n;

   always_comb begin
      req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++)
         req_ready[k] = (gnt_a && a_idx == IDX_W'(k)) || (gnt_b && b_idx == IDX_W'(k));
   end

   assign ena   = gnt_a;
   assign wea   = gnt_a & req_we[a_idx];
   assign addra = gnt_a ? addr[a_idx] : '0;
   assign dina  = gnt_a ? wdata[a_idx] : '0;
   assign enb   = gnt_b;
   assign web   = gnt_b & req_we[b_idx];
   assign addrb = gnt_b ? addr[b_idx] : '0;
   assign dinb  = gnt_b ? wdata[b_idx] : '0;

   assign last_idx    = gnt_b ? b_idx : a_idx;
   assign rr_d        = !gnt_a ? rr_q : (last_idx == IDX_W'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
   assign tag_a_vld_d = gnt_a & ~req_we[a_idx];
   assign tag_b_vld_d = gnt_b & ~req_we[b_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q        <= '0;
         tag_a_vld_q <= 1'b0;
         tag_b_vld_q <= 1'b0;
         tag_a_idx_q <= '0;
         tag_b_idx_q <= '0;
      end else begin
         rr_q        <= rr_d;
         tag_a_vld_q <= tag_a_vld_d;
         tag_b_vld_q <= tag_b_vld_d;
         tag_a_idx_q <= a_idx;
         tag_b_idx_q <= b_idx;
      end
   end

   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rsp_valid[k] = (tag_a_vld_q && tag_a_idx_q == IDX_W'(k)) || (tag_b_vld_q && tag_b_idx_q == IDX_W'(k));
         rsp_rdata[k*DATA_WIDTH +: DATA_WIDTH] = (tag_a_vld_q && tag_a_idx_q == IDX_W'(k)) ? douta :
                                                 (tag_b_vld_q && tag_b_idx_q == IDX_W'(k)) ? doutb : '0;
      end
   end
endmodule

// File: tb/tb_tdp_ram_arbiter.sv
// tb_tdp_ram_arbiter: directed bench with a behavioural one-cycle RAM behind both arbiter ports.
module tb_tdp_ram_arbiter;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req_valid = '0, req_we = '0, req_ready, rsp_valid;
   logic [39:0]  req_addr = '0;
   logic [127:0] req_wdata = '0, rsp_rdata;
   logic         ena, wea, enb, web;
   logic [9:0]   addra, addrb;
   logic [31:0]  dina, dinb, douta, doutb;
   logic [31:0]  mem [1024];
   int           checks = 0, failures = 0;

   tdp_ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_REQ(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
      .douta(douta), .doutb(doutb)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ena) begin
         if (wea) mem[addra] <= dina;
         else douta <= mem[addra];
      end
      if (enb) begin
         if (web) mem[addrb] <= dinb;
         else doutb <= mem[addrb];
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic w, input logic [9:0] a, input logic [31:0] d);
      req_valid[i] = v;
      req_we[i] = w;
      req_addr[i*10 +: 10] = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   task automatic clr();
      req_valid = '0;
      req_we = '0;
      req_addr = '0;
      req_wdata = '0;
   endtask

   task automatic issue();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset: grants and RAM enables forced off even with a valid request
      set_req(0, 1, 0, 10'h010, 0);
      @(negedge clk); #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_ena", ena, 0);
      chk("rst_enb", enb, 0);
      chk("rst_rsp", rsp_valid, 0);
      clr();
      @(negedge clk); rst_n = 1'b1; #1;
      chk("post_rst_outs", {req_ready, rsp_valid, ena, wea, enb, web, addra, addrb, dina, dinb}, 0);
      chk("post_rst_rdata", rsp_rdata, 0);

      // single requester write then read (ptr 0 -> 1 -> 1)
      @(negedge clk); set_req(0, 1, 1, 10'h010, 32'hDEADBEEF); #1;
      chk("wr_ready", req_ready, 4'b0001);
      chk("wr_porta", {ena, wea, addra, dina}, {1'b1, 1'b1, 10'h010, 32'hDEADBEEF});
      chk("wr_enb", enb, 0);
      issue();
      chk("wr_no_rsp", rsp_valid, 0);
      @(negedge clk); set_req(0, 1, 0, 10'h010, 0); #1;
      chk("rd_ready", req_ready, 4'b0001);
      chk("rd_porta", {ena, wea, addra}, {1'b1, 1'b0, 10'h010});
      issue();
      chk("rd_rsp", rsp_valid, 4'b0001);
      chk("rd_data", rsp_rdata, {96'h0, 32'hDEADBEEF});

      // preload two words via a dual write (ptr 1 -> 3)
      @(negedge clk); clr(); set_req(1, 1, 1, 10'h005, 32'h11); set_req(2, 1, 1, 10'h006, 32'h22); #1;
      chk("dwr_ready", req_ready, 4'b0110);
      chk("dwr_portb", {enb, web, addrb, dinb}, {1'b1, 1'b1, 10'h006, 32'h22});
      issue();
      // dual read, ptr 3 scans 3,0,1,2 -> A=1, B=2 (ptr -> 3)
      @(negedge clk); set_req(1, 1, 0, 10'h005, 0); set_req(2, 1, 0, 10'h006, 0); #1;
      chk("drd_ready", req_ready, 4'b0110);
      chk("drd_ports", {ena, wea, addra, enb, web, addrb}, {1'b1, 1'b0, 10'h005, 1'b1, 1'b0, 10'h006});
      issue();
      chk("drd_rsp", rsp_valid, 4'b0110);
      chk("drd_data", rsp_rdata, {32'h0, 32'h22, 32'h11, 32'h0});

      // rotation: req3 alone (ptr 3 -> 0), then req3+req0 -> A=0, B=3 (ptr -> 0)
      @(negedge clk); clr(); set_req(3, 1, 0, 10'h010, 0); #1;
      chk("rot1_ready", req_ready, 4'b1000);
      chk("rot1_porta", {ena, addra, enb}, {1'b1, 10'h010, 1'b0});
      issue();
      chk("rot1_data", {rsp_valid, rsp_rdata}, {4'b1000, 32'hDEADBEEF, 96'h0});
      @(negedge clk); set_req(3, 1, 0, 10'h006, 0); set_req(0, 1, 0, 10'h005, 0); #1;
      chk("rot2_ready", req_ready, 4'b1001);
      chk("rot2_addr", {addra, addrb}, {10'h005, 10'h006});
      issue();
      chk("rot2_data", {rsp_valid, rsp_rdata}, {4'b1001, 32'h22, 64'h0, 32'h11});

      // hazard: req0 write / req1 read same address, ptr 0 -> only req0 (ptr -> 1)
      @(negedge clk); clr(); set_req(0, 1, 1, 10'h020, 32'hCAFEF00D); set_req(1, 1, 0, 10'h020, 0); #1;
      chk("haz_ready", req_ready, 4'b0001);
      chk("haz_enb", enb, 0);
      issue();
      chk("haz_no_rsp", rsp_valid, 0);
      @(negedge clk); set_req(0, 0, 0, 0, 0); #1;
      chk("haz2_ready", req_ready, 4'b0010);
      issue();
      chk("haz2_data", {rsp_valid, rsp_rdata}, {4'b0010, 64'h0, 32'hCAFEF00D, 32'h0});
      // read/read same address, ptr 2 -> both (ptr -> 0)
      @(negedge clk); clr(); set_req(2, 1, 0, 10'h020, 0); set_req(3, 1, 0, 10'h020, 0); #1;
      chk("rr_same_ready", req_ready, 4'b1100);
      issue();
      chk("rr_same_data", {rsp_valid, rsp_rdata}, {4'b1100, 32'hCAFEF00D, 32'hCAFEF00D, 64'h0});
      // conflicting req1 skipped, B goes to req2 (ptr 0 -> 3)
      @(negedge clk); clr(); set_req(0, 1, 1, 10'h030, 32'h33); set_req(1, 1, 0, 10'h030, 0);
      set_req(2, 1, 0, 10'h005, 0); #1;
      chk("skip_ready", req_ready, 4'b0101);
      chk("skip_addrb", {enb, addrb}, {1'b1, 10'h005});
      issue();
      chk("skip_data", {rsp_valid, rsp_rdata}, {4'b0100, 32'h0, 32'h11, 64'h0});

      // reset mid-operation: req2 read granted (ptr 3 -> A=2), reset right after the edge
      @(negedge clk); clr(); set_req(2, 1, 0, 10'h006, 0); #1;
      chk("mid_ready", req_ready, 4'b0100);
      @(posedge clk); #1; rst_n = 1'b0; #1;
      chk("mid_rst_rsp", rsp_valid, 0);
      chk("mid_rst_ready", {req_ready, ena, enb}, 0);
      @(negedge clk); clr(); #1;
      chk("mid_rst_rsp2", rsp_valid, 0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("mid_rel_outs", {req_ready, rsp_valid, ena, wea, enb, web, addra, addrb, dina, dinb}, 0);
      chk("mid_rel_rdata", rsp_rdata, 0);
      issue();
      chk("mid_rel_rsp", rsp_valid, 0);

      // fairness from reset: pairs {0,1},{2,3},... each with a response the next cycle
      @(negedge clk);
      set_req(0, 1, 0, 10'h005, 0); set_req(1, 1, 0, 10'h006, 0);
      set_req(2, 1, 0, 10'h010, 0); set_req(3, 1, 0, 10'h020, 0);
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("fair_ready_%0d", c), req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
         issue();
         chk($sformatf("fair_rsp_%0d", c), {rsp_valid, rsp_rdata}, (c % 2 == 0) ?
             {4'b0011, 64'h0, 32'h22, 32'h11} : {4'b1100, 32'hCAFEF00D, 32'hDEADBEEF, 64'h0});
         @(negedge clk);
      end
      clr();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tdp_ram_arbiter.md
# tdp_ram_arbiter

Single-clock arbiter that shares one `true_dp_ram` instance among `NUM_REQ` requesters. Each cycle it grants up to two requests in round-robin order, one on RAM port A and one on port B. It blocks same-address hazards between the two ports and returns read data to the originating requester one cycle after issue. It sits between requester logic and the RAM; both RAM clocks are tied to `clk`.

## Interface
- `DATA_WIDTH`, 32, RAM word width
- `ADDR_WIDTH`, 10, RAM address width
- `NUM_REQ`, 4, number of requesters (legal 2..8); `IDX_W = $clog2(NUM_REQ)` local

Clock/reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock for all logic and both RAM ports
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in NUM_REQ: request valid, one bit per requester
- `req_ready` out NUM_REQ: request accepted this cycle (grant)
- `req_we` in NUM_REQ: 1 = write, 0 = read
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses, requester i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data
- `rsp_valid` out NUM_REQ: read data valid for requester i
- `rsp_rdata` out NUM_REQ*DATA_WIDTH: packed read data
- `ena`, `wea` out 1; `addra` out ADDR_WIDTH; `dina` out DATA_WIDTH: RAM port A
- `enb`, `web` out 1; `addrb` out ADDR_WIDTH; `dinb` out DATA_WIDTH: RAM port B
- `douta`, `doutb` in DATA_WIDTH: RAM read data, valid 1 cycle after read issue

## Operation
- Handshake: a transfer occurs when `req_valid[i] && req_ready[i]`. Requester i holds `req_we`, `req_addr` and `req_wdata` stable while valid and not ready. `req_ready` is combinational from the current cycle's arbitration and never asserts without `req_valid`.
- Round-robin pointer `rr_ptr` (IDX_W bits):
  - Scan order is `rr_ptr, rr_ptr+1, … (mod NUM_REQ)`.
  - The first valid requester in scan order wins port A.
  - Scanning continues from the A winner. The first later valid requester that does not conflict with the A winner wins port B.
  - Conflict = equal address AND at least one of the two is a write. Read/read to the same address is not a conflict.
  - A conflicting requester is skipped this cycle only; it stays valid and is reconsidered next cycle.
- Pointer update on a clock edge:
  - If anything was granted, `rr_ptr <= (last granted index + 1) mod NUM_REQ`. The last granted index is the B winner if one exists, otherwise the A winner.
  - If nothing was granted, `rr_ptr` is held.
- RAM drive: for a granted port, en=1, we=`req_we`, addr/din from the winner. For an idle port, en=0, we=0, addr=0, din=0.
- Response tracking: registers `tag_a_vld`, `tag_a_idx`, `tag_b_vld`, `tag_b_idx` capture granted reads (writes are not tracked) at each edge.
  - Next cycle: `rsp_valid[tag_a_idx] = tag_a_vld` with data = `douta`. Port B is handled the same way with `doutb`.
  - Both ports can respond to different requesters in the same cycle. One requester never receives two responses in one cycle, because at most one grant per requester per cycle.
  - `rsp_rdata` lanes with `rsp_valid` low are 0.
- Writes are fire-and-forget and produce no response.
- Reset (`rst_n`=0, asynchronous):
  - `rr_ptr`=0, all tag valid bits 0, so `rsp_valid`=0.
  - While `rst_n` is low, `req_ready`, `ena`, `wea`, `enb`, `web` are forced 0.
  - In-flight reads at reset assertion are dropped; no response is ever produced for them.

## Timing
- Grant: combinational, same cycle as `req_valid`. RAM access happens at the next rising edge.
- Read latency: a read accepted in cycle T gets `rsp_valid` in cycle T+1.
- Throughput: two accesses per cycle, one sustained access per requester per cycle.
- Write-then-read: a write accepted at T and a read of the same address accepted at T+1 or later returns the new data. The conflict rule guarantees no same-cycle read/write collision.
- Fairness: any continuously valid requester is granted within `ceil(NUM_REQ/2)+1` cycles.
- Outputs after reset release: all outputs 0 until the first `req_valid`.

## Test plan
- Single requester: req0 writes 0xDEADBEEF to addr 0x010, then reads 0x010 → `req_ready[0]` each cycle; next cycle `rsp_valid`=0001, `rsp_rdata` lane 0 = 0xDEADBEEF.
- Dual read: req1 reads 0x005 and req2 reads 0x006 in the same cycle (data 0x11 and 0x22 preloaded) → both ready; next cycle `rsp_valid`=0110, lane 1 = 0x11, lane 2 = 0x22.
- Hazard: req0 writes 0x020 and req1 reads 0x020 in the same cycle, `rr_ptr`=0 → only req0 granted; req1 granted next cycle and reads the written value. A read/read to the same address grants both.
- Fairness: all 4 requesters issue continuous reads from reset → grant pairs {0,1},{2,3},{0,1},… every cycle, each `rsp_valid` one cycle after its grant.
- Rotation: only req3 valid, then req3 and req0 together → first cycle A=3, pointer goes to 0; next cycle A=0, B=3.
- Reset mid-operation: assert `rst_n` low in the cycle after req2's read is granted → `rsp_valid` never asserts for it; after release, `rr_ptr`=0 and all outputs are 0.
